// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit display scanner: slot timing with a blank guard period,
// double-buffered digit codes swapped only at frame wrap.
// Optional build macro LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] D0,
  input  logic [4:0] D1,
  input  logic [4:0] D2,
  input  logic [4:0] D3,
  output logic       V,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic [3:0] AN,
  output logic       frame_done
);

  localparam int              CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   TC_VAL  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   GRD_VAL = CW'(GUARD_CYC);
  localparam logic [4:0]      BLANK   = 5'h1F;

  typedef enum logic {S_GUARD, S_DRIVE} scan_state_e;

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic            r_pending;
  logic [3:0][4:0] r_shadow;
  logic [3:0][4:0] r_active;
  logic [3:0]      r_an;
  logic [4:0]      r_code;
  logic            r_fd;

  scan_state_e     w_state;
  logic            w_tc;
  logic            w_wrap;
  logic [3:0][4:0] w_din;
  logic [3:0][4:0] w_disp;
  logic [3:0]      w_an_nxt;
  logic [4:0]      w_code_nxt;

  assign w_tc   = (r_cnt == TC_VAL);
  assign w_wrap = en && w_tc && (r_idx == 2'd3);
  assign w_din  = {D3, D2, D1, D0};

  // Tick counter and digit index; both freeze while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      if (w_tc) r_idx <= r_idx + 2'd1;
    end
  end

  // Double buffer: active only changes at frame wrap, so no digit ever tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_shadow  <= {4{BLANK}};
      r_active  <= {4{BLANK}};
    end else begin
      if (load) r_shadow <= w_din;
      if (w_wrap) begin
        r_pending <= 1'b0;
        if (load)           r_active <= w_din;
        else if (r_pending) r_active <= r_shadow;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_disp = r_active;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic hi_empty;
      hi_empty = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (hi_empty && (r_active[i] == 5'd0)) w_disp[i] = BLANK;
        hi_empty = hi_empty && ((r_active[i] == 5'd0) || (r_active[i] == BLANK));
      end
    end
`endif
  end

  always_comb begin
    w_state    = (r_cnt < GRD_VAL) ? S_GUARD : S_DRIVE;
    w_an_nxt   = 4'b1111;
    w_code_nxt = w_disp[r_idx];
    if (en && (w_state == S_DRIVE)) w_an_nxt = ~(4'b0001 << r_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an   <= 4'b1111;
      r_code <= BLANK;
      r_fd   <= 1'b0;
    end else begin
      r_an   <= w_an_nxt;
      r_code <= w_code_nxt;
      r_fd   <= w_wrap;
    end
  end

  assign {V, W, X, Y, Z} = r_code;
  assign AN              = r_an;
  assign frame_done      = r_fd;

endmodule
